// File: rtl/uart_axil_arbiter_if.sv
// uart_axil_arbiter_if: requester-side and AXI4-Lite master signals of the UART arbiter.
// The master modport is the arbiter's view. The slave modport is the environment's view
// (the requesters plus the UART register slave).
interface uart_axil_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Requester side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ*STRB_WIDTH-1:0] req_wstrb;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [NUM_REQ-1:0]            resp_ready;
    logic [DATA_WIDTH-1:0]         resp_rdata;
    logic                          resp_err;
    logic                          busy;

    // AXI4-Lite master towards the UART register port
    logic [ADDR_WIDTH-1:0]         uart_axi_awaddr;
    logic                          uart_axi_awvalid;
    logic                          uart_axi_awready;
    logic [DATA_WIDTH-1:0]         uart_axi_wdata;
    logic [STRB_WIDTH-1:0]         uart_axi_wstrb;
    logic                          uart_axi_wvalid;
    logic                          uart_axi_wready;
    logic [1:0]                    uart_axi_bresp;
    logic                          uart_axi_bvalid;
    logic                          uart_axi_bready;
    logic [ADDR_WIDTH-1:0]         uart_axi_araddr;
    logic                          uart_axi_arvalid;
    logic                          uart_axi_arready;
    logic [DATA_WIDTH-1:0]         uart_axi_rdata;
    logic [1:0]                    uart_axi_rresp;
    logic                          uart_axi_rvalid;
    logic                          uart_axi_rready;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
        output uart_axi_awaddr, uart_axi_awvalid, uart_axi_wdata, uart_axi_wstrb,
        output uart_axi_wvalid, uart_axi_bready, uart_axi_araddr, uart_axi_arvalid,
        output uart_axi_rready,
        input  uart_axi_awready, uart_axi_wready, uart_axi_bresp, uart_axi_bvalid,
        input  uart_axi_arready, uart_axi_rdata, uart_axi_rresp, uart_axi_rvalid
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
        input  uart_axi_awaddr, uart_axi_awvalid, uart_axi_wdata, uart_axi_wstrb,
        input  uart_axi_wvalid, uart_axi_bready, uart_axi_araddr, uart_axi_arvalid,
        input  uart_axi_rready,
        output uart_axi_awready, uart_axi_wready, uart_axi_bresp, uart_axi_bvalid,
        output uart_axi_arready, uart_axi_rdata, uart_axi_rresp, uart_axi_rvalid
    );
endinterface

// File: rtl/uart_axil_arbiter.sv
// uart_axil_arbiter: round-robin sharing of one AXI4-Lite UART register port among
// NUM_REQ requesters, with a single outstanding transaction at a time.
// Optional feature: define UART_ARB_TIMEOUT_EN to add a watchdog. When the watchdog
// expires, the transaction is aborted and completes with an error response.
module uart_axil_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                 sys_clk,
    input logic                 sys_rst_n,
    uart_axil_arbiter_if.master bus
);
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR, BWAIT, RD, RWAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [IDX_W-1:0]        rr_idx;
    logic [IDX_W-1:0]        rr_grant;
    logic                    rr_found;
    logic                    unused_bits;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    timeout_q, timeout_d;
    assign unused_bits = ^{bus.uart_axi_bresp[0], bus.uart_axi_rresp[0]};
`else
    assign unused_bits = ^{bus.uart_axi_bresp[0], bus.uart_axi_rresp[0], 32'(TIMEOUT_CYCLES)};
`endif

    // Round-robin search: the first valid requester after last_grant wins, and last_grant itself is tried last
    always_comb begin
        rr_found = 1'b0;
        rr_grant = last_grant_q;
        rr_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_idx = IDX_W'((int'(last_grant_q) + i) % NUM_REQ);
            if (!rr_found && bus.req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_grant = rr_idx;
            end
        end
    end

    // Transaction FSM: next state, captured request and response fields, and the handshake outputs
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
`ifdef UART_ARB_TIMEOUT_EN
        timer_d      = timer_q;
        timeout_d    = timeout_q;
`endif
        bus.req_ready        = '0;
        bus.resp_valid       = '0;
        bus.uart_axi_awvalid = 1'b0;
        bus.uart_axi_wvalid  = 1'b0;
        bus.uart_axi_bready  = 1'b0;
        bus.uart_axi_arvalid = 1'b0;
        bus.uart_axi_rready  = 1'b0;

        case (state_q)
            IDLE: begin
                // Ready stays low while reset is held, even though the state already reads IDLE
                if (rr_found && sys_rst_n) begin
                    bus.req_ready[rr_grant] = 1'b1;
                    grant_d   = rr_grant;
                    addr_d    = bus.req_addr[rr_grant*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d   = bus.req_wdata[rr_grant*DATA_WIDTH +: DATA_WIDTH];
                    wstrb_d   = bus.req_wstrb[rr_grant*STRB_WIDTH +: STRB_WIDTH];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = bus.req_we[rr_grant] ? WR : RD;
`ifdef UART_ARB_TIMEOUT_EN
                    timer_d   = '0;
`endif
                end
            end
            WR: begin
                bus.uart_axi_awvalid = !aw_done_q;
                bus.uart_axi_wvalid  = !w_done_q;
                aw_done_d = aw_done_q | bus.uart_axi_awready;
                w_done_d  = w_done_q | bus.uart_axi_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = BWAIT;
                end
            end
            BWAIT: begin
                bus.uart_axi_bready = 1'b1;
                if (bus.uart_axi_bvalid) begin
                    err_d   = bus.uart_axi_bresp[1];
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RD: begin
                bus.uart_axi_arvalid = 1'b1;
                if (bus.uart_axi_arready) begin
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                bus.uart_axi_rready = 1'b1;
                if (bus.uart_axi_rvalid) begin
                    rdata_d = bus.uart_axi_rdata;
                    err_d   = bus.uart_axi_rresp[1];
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.resp_valid[grant_q] = 1'b1;
                if (bus.resp_ready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog recovery deliberately abandons AXI valid-hold so that a dead slave cannot wedge the port
        if (state_q == WR || state_q == BWAIT || state_q == RD || state_q == RWAIT) begin
            timer_d = timer_q + 1'b1;
            if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                bus.uart_axi_awvalid = 1'b0;
                bus.uart_axi_wvalid  = 1'b0;
                bus.uart_axi_bready  = 1'b0;
                bus.uart_axi_arvalid = 1'b0;
                bus.uart_axi_rready  = 1'b0;
                err_d     = 1'b1;
                rdata_d   = DATA_WIDTH'(32'hDEAD_0BAD);
                timeout_d = 1'b1;
                state_d   = RESP;
            end
        end
`endif
    end

    // Registers: reset leaves the port idle, with requester 0 first in line
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    assign bus.uart_axi_awaddr = addr_q;
    assign bus.uart_axi_araddr = addr_q;
    assign bus.uart_axi_wdata  = wdata_q;
    assign bus.uart_axi_wstrb  = wstrb_q;
    assign bus.resp_rdata      = rdata_q;
    assign bus.resp_err        = err_q;
    assign bus.busy            = (state_q != IDLE);
endmodule

// File: tb/tb_uart_axil_arbiter.sv
// tb_uart_axil_arbiter: directed bench for uart_axil_arbiter with two requesters.
// The slave side is driven cycle by cycle from the stimulus sequence.
// If UART_ARB_TIMEOUT_EN is defined, the watchdog path is also exercised (TIMEOUT_CYCLES=16).
module tb_uart_axil_arbiter;
    logic sys_clk;
    logic sys_rst_n;
    int   assertCount;
    int   failCount;

    uart_axil_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(13), .DATA_WIDTH(32)) bus ();

    uart_axil_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(13), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus(bus)
    );

    // Free-running 100 MHz clock
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic nextCycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic we,
                                 input logic [12:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb);
        bus.req_valid[idx]          = valid;
        bus.req_we[idx]             = we;
        bus.req_addr[idx*13 +: 13]  = addr;
        bus.req_wdata[idx*32 +: 32] = wdata;
        bus.req_wstrb[idx*4 +: 4]   = wstrb;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence: reset, single write, single read, contention, skewed write, reset mid-read
    initial begin
        assertCount = 0;
        failCount   = 0;
        sys_rst_n   = 1'b0;
        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_wstrb = '0; bus.resp_ready = '0;
        bus.uart_axi_awready = 1'b0; bus.uart_axi_wready = 1'b0;
        bus.uart_axi_bresp = 2'b00; bus.uart_axi_bvalid = 1'b0;
        bus.uart_axi_arready = 1'b0; bus.uart_axi_rdata = '0;
        bus.uart_axi_rresp = 2'b00; bus.uart_axi_rvalid = 1'b0;
        #2;
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        checkOutput("rst_awvalid", 32'(bus.uart_axi_awvalid), 32'h0);
        checkOutput("rst_wvalid", 32'(bus.uart_axi_wvalid), 32'h0);
        checkOutput("rst_arvalid", 32'(bus.uart_axi_arvalid), 32'h0);
        checkOutput("rst_bready", 32'(bus.uart_axi_bready), 32'h0);
        checkOutput("rst_rready", 32'(bus.uart_axi_rready), 32'h0);
        checkOutput("rst_rdata", bus.resp_rdata, 32'h0);
        checkOutput("rst_err", 32'(bus.resp_err), 32'h0);
        nextCycle();
        nextCycle();
        sys_rst_n = 1'b1;
        nextCycle();
        settle();
        checkOutput("idle_busy", 32'(bus.busy), 32'h0);

        // Single write from requester 0 with a zero-wait slave
        applyStimulus(0, 1'b1, 1'b1, 13'h1004, 32'h41, 4'h1);
        bus.uart_axi_awready = 1'b1;
        bus.uart_axi_wready  = 1'b1;
        settle();
        checkOutput("wr_accept_ready", 32'(bus.req_ready), 32'h1);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        settle();
        checkOutput("wr_t1_awvalid", 32'(bus.uart_axi_awvalid), 32'h1);
        checkOutput("wr_t1_wvalid", 32'(bus.uart_axi_wvalid), 32'h1);
        checkOutput("wr_t1_awaddr", 32'(bus.uart_axi_awaddr), 32'h1004);
        checkOutput("wr_t1_wdata", bus.uart_axi_wdata, 32'h41);
        checkOutput("wr_t1_wstrb", 32'(bus.uart_axi_wstrb), 32'h1);
        checkOutput("wr_t1_busy", 32'(bus.busy), 32'h1);
        checkOutput("wr_t1_no_ready", 32'(bus.req_ready), 32'h0);
        nextCycle();
        bus.uart_axi_bvalid = 1'b1;
        bus.uart_axi_bresp  = 2'b00;
        settle();
        checkOutput("wr_t2_bready", 32'(bus.uart_axi_bready), 32'h1);
        checkOutput("wr_t2_awvalid", 32'(bus.uart_axi_awvalid), 32'h0);
        checkOutput("wr_t2_wvalid", 32'(bus.uart_axi_wvalid), 32'h0);
        nextCycle();
        bus.uart_axi_bvalid = 1'b0;
        bus.uart_axi_awready = 1'b0;
        bus.uart_axi_wready  = 1'b0;
        bus.resp_ready = 2'b10;
        settle();
        checkOutput("wr_t3_resp_valid", 32'(bus.resp_valid), 32'h1);
        checkOutput("wr_t3_err", 32'(bus.resp_err), 32'h0);
        checkOutput("wr_t3_rdata", bus.resp_rdata, 32'h0);
        nextCycle();
        bus.resp_ready = 2'b01;
        settle();
        checkOutput("wr_foreign_ready_ignored", 32'(bus.resp_valid), 32'h1);
        nextCycle();
        bus.resp_ready = 2'b00;
        bus.uart_axi_bvalid = 1'b1;
        settle();
        checkOutput("wr_done_busy", 32'(bus.busy), 32'h0);
        checkOutput("stray_bvalid_bready", 32'(bus.uart_axi_bready), 32'h0);
        checkOutput("wr_done_resp_valid", 32'(bus.resp_valid), 32'h0);
        nextCycle();
        bus.uart_axi_bvalid = 1'b0;

        // Single read from requester 1
        applyStimulus(1, 1'b1, 1'b0, 13'h1008, 32'h0, 4'h0);
        settle();
        checkOutput("rd_accept_ready", 32'(bus.req_ready), 32'h2);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        bus.uart_axi_arready = 1'b1;
        settle();
        checkOutput("rd_t1_arvalid", 32'(bus.uart_axi_arvalid), 32'h1);
        checkOutput("rd_t1_araddr", 32'(bus.uart_axi_araddr), 32'h1008);
        nextCycle();
        bus.uart_axi_arready = 1'b0;
        bus.uart_axi_rvalid  = 1'b1;
        bus.uart_axi_rdata   = 32'h60;
        bus.uart_axi_rresp   = 2'b00;
        settle();
        checkOutput("rd_t2_rready", 32'(bus.uart_axi_rready), 32'h1);
        checkOutput("rd_t2_arvalid", 32'(bus.uart_axi_arvalid), 32'h0);
        nextCycle();
        bus.uart_axi_rvalid = 1'b0;
        bus.uart_axi_rdata  = 32'h0;
        settle();
        checkOutput("rd_t3_resp_valid", 32'(bus.resp_valid), 32'h2);
        checkOutput("rd_t3_rdata", bus.resp_rdata, 32'h60);
        checkOutput("rd_t3_err", 32'(bus.resp_err), 32'h0);
        bus.resp_ready = 2'b10;
        nextCycle();
        bus.resp_ready = 2'b00;
        settle();
        checkOutput("rd_done_busy", 32'(bus.busy), 32'h0);

        // Contention: both requesters valid across reset release, then held for four reads
        sys_rst_n = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 13'h1010, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b0, 13'h1014, 32'h0, 4'h0);
        settle();
        checkOutput("rst_held_req_ready", 32'(bus.req_ready), 32'h0);
        nextCycle();
        sys_rst_n = 1'b1;
        settle();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("rr%0d_grant", k), 32'(bus.req_ready), 32'(1 << (k % 2)));
            nextCycle();
            bus.uart_axi_arready = 1'b1;
            settle();
            checkOutput($sformatf("rr%0d_waiter_held", k), 32'(bus.req_ready), 32'h0);
            checkOutput($sformatf("rr%0d_araddr", k), 32'(bus.uart_axi_araddr),
                        (k % 2 == 0) ? 32'h1010 : 32'h1014);
            nextCycle();
            bus.uart_axi_arready = 1'b0;
            bus.uart_axi_rvalid  = 1'b1;
            bus.uart_axi_rdata   = 32'h100 + 32'(k);
            nextCycle();
            bus.uart_axi_rvalid  = 1'b0;
            bus.resp_ready = 2'(1 << (k % 2));
            settle();
            checkOutput($sformatf("rr%0d_resp_valid", k), 32'(bus.resp_valid), 32'(1 << (k % 2)));
            checkOutput($sformatf("rr%0d_rdata", k), bus.resp_rdata, 32'h100 + 32'(k));
            nextCycle();
            bus.resp_ready = 2'b00;
            settle();
        end
        applyStimulus(0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        nextCycle();

        // Skewed write handshake: wready three cycles ahead of awready, then SLVERR
        applyStimulus(0, 1'b1, 1'b1, 13'h1018, 32'h55AA, 4'h3);
        settle();
        checkOutput("skew_accept_ready", 32'(bus.req_ready), 32'h1);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        bus.uart_axi_wready = 1'b1;
        settle();
        checkOutput("skew_c1_awvalid", 32'(bus.uart_axi_awvalid), 32'h1);
        checkOutput("skew_c1_wvalid", 32'(bus.uart_axi_wvalid), 32'h1);
        nextCycle();
        bus.uart_axi_wready = 1'b0;
        settle();
        checkOutput("skew_c2_wvalid", 32'(bus.uart_axi_wvalid), 32'h0);
        checkOutput("skew_c2_awvalid", 32'(bus.uart_axi_awvalid), 32'h1);
        checkOutput("skew_c2_bready", 32'(bus.uart_axi_bready), 32'h0);
        nextCycle();
        settle();
        checkOutput("skew_c3_awvalid", 32'(bus.uart_axi_awvalid), 32'h1);
        nextCycle();
        bus.uart_axi_awready = 1'b1;
        settle();
        checkOutput("skew_c4_awvalid", 32'(bus.uart_axi_awvalid), 32'h1);
        checkOutput("skew_c4_wvalid", 32'(bus.uart_axi_wvalid), 32'h0);
        nextCycle();
        bus.uart_axi_awready = 1'b0;
        bus.uart_axi_bvalid  = 1'b1;
        bus.uart_axi_bresp   = 2'b10;
        settle();
        checkOutput("skew_bwait_awvalid", 32'(bus.uart_axi_awvalid), 32'h0);
        checkOutput("skew_bwait_bready", 32'(bus.uart_axi_bready), 32'h1);
        nextCycle();
        bus.uart_axi_bvalid = 1'b0;
        bus.uart_axi_bresp  = 2'b00;
        settle();
        checkOutput("skew_single_bready", 32'(bus.uart_axi_bready), 32'h0);
        checkOutput("skew_resp_valid", 32'(bus.resp_valid), 32'h1);
        checkOutput("skew_resp_err", 32'(bus.resp_err), 32'h1);
        bus.resp_ready = 2'b01;
        nextCycle();
        bus.resp_ready = 2'b00;

        // Reset asserted while waiting for read data aborts the transaction
        applyStimulus(1, 1'b1, 1'b0, 13'h100C, 32'h0, 4'h0);
        settle();
        checkOutput("rstrd_accept_ready", 32'(bus.req_ready), 32'h2);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        bus.uart_axi_arready = 1'b1;
        nextCycle();
        bus.uart_axi_arready = 1'b0;
        settle();
        checkOutput("rstrd_rwait_rready", 32'(bus.uart_axi_rready), 32'h1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("rstrd_arvalid", 32'(bus.uart_axi_arvalid), 32'h0);
        checkOutput("rstrd_rready", 32'(bus.uart_axi_rready), 32'h0);
        checkOutput("rstrd_resp_valid", 32'(bus.resp_valid), 32'h0);
        checkOutput("rstrd_busy", 32'(bus.busy), 32'h0);
        nextCycle();
        sys_rst_n = 1'b1;
        settle();
        checkOutput("rstrd_after_busy", 32'(bus.busy), 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 13'h1000, 32'h0, 4'h0);
        settle();
        checkOutput("rstrd_next_ready", 32'(bus.req_ready), 32'h1);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        bus.uart_axi_arready = 1'b1;
        nextCycle();
        bus.uart_axi_arready = 1'b0;
        bus.uart_axi_rvalid  = 1'b1;
        bus.uart_axi_rdata   = 32'h1234;
        nextCycle();
        bus.uart_axi_rvalid  = 1'b0;
        settle();
        checkOutput("rstrd_next_resp_valid", 32'(bus.resp_valid), 32'h1);
        checkOutput("rstrd_next_rdata", bus.resp_rdata, 32'h1234);
        bus.resp_ready = 2'b01;
        nextCycle();
        bus.resp_ready = 2'b00;
        settle();
        checkOutput("rstrd_next_done", 32'(bus.busy), 32'h0);

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: the slave never raises arready
        applyStimulus(1, 1'b1, 1'b0, 13'h1020, 32'h0, 4'h0);
        settle();
        checkOutput("to_accept_ready", 32'(bus.req_ready), 32'h2);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        settle();
        checkOutput("to_first_arvalid", 32'(bus.uart_axi_arvalid), 32'h1);
        repeat (15) nextCycle();
        settle();
        checkOutput("to_last_arvalid_dropped", 32'(bus.uart_axi_arvalid), 32'h0);
        checkOutput("to_last_no_resp", 32'(bus.resp_valid), 32'h0);
        nextCycle();
        settle();
        checkOutput("to_resp_valid", 32'(bus.resp_valid), 32'h2);
        checkOutput("to_resp_err", 32'(bus.resp_err), 32'h1);
        checkOutput("to_resp_rdata", bus.resp_rdata, 32'hDEAD_0BAD);
        checkOutput("to_flag", 32'(dut.timeout_q), 32'h1);
        bus.resp_ready = 2'b10;
        nextCycle();
        bus.resp_ready = 2'b00;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/uart_axil_arbiter.md
Name: uart_axil_arbiter

Overview:
- Shares the single AXI4-Lite UART register port (13-bit address, 32-bit data) between NUM_REQ on-chip requesters, e.g. the chipset NoC-to-UART bridge and the PCIe/debug console path.
- Arbitrates round-robin and allows one outstanding transaction at a time.
- Drives the AXI4-Lite write and read channels and returns the response to the granted requester.
- Sits between the requesters and the uart_axi_* port of the system top.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- ADDR_WIDTH, 13: AXI4-Lite address width.
- DATA_WIDTH, 32: AXI4-Lite data width; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024: watchdog limit, used only with UART_ARB_TIMEOUT_EN.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_wstrb  in  NUM_REQ*DATA_WIDTH/8  packed write strobes.
- req_ready  out  NUM_REQ  request accepted (one-hot).
- resp_valid  out  NUM_REQ  response valid (one-hot).
- resp_ready  in  NUM_REQ  response consumed.
- resp_rdata  out  DATA_WIDTH  read data, shared by all requesters.
- resp_err  out  1  1 if bresp/rresp bit[1] was set.
- busy  out  1  high when not IDLE.
- uart_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master, widths per parameters.

Behaviour:
- Reset: sys_rst_n is asynchronous and active-low. While low, every valid, ready and busy output is 0, resp_rdata is 0, resp_err is 0, state is IDLE, and last_grant is NUM_REQ-1 so requester 0 wins first.
- States: IDLE, WR, BWAIT, RD, RWAIT, RESP.
- IDLE:
  - Grant g is the first asserted req_valid searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - req_ready[g] is asserted combinationally in the same cycle, and only in IDLE.
  - addr, wdata, wstrb and we are latched. Next state is WR if we=1, otherwise RD.
  - Requesters hold all request fields stable until req_ready is asserted.
- WR:
  - awvalid and wvalid assert together in the first cycle of WR.
  - Each deasserts independently after its ready is sampled high; a done flag is kept per channel.
  - When both are done, go to BWAIT. If both readies are seen in the same cycle, move to BWAIT in the next cycle.
- BWAIT: bready=1. On bvalid, capture resp_err=bresp[1] and set rdata=0, then go to RESP.
- RD: arvalid=1 until arready is sampled high, then go to RWAIT.
- RWAIT: rready=1. On rvalid, capture rdata and resp_err=rresp[1], then go to RESP.
- RESP:
  - resp_valid[g]=1, with resp_rdata and resp_err held stable.
  - On resp_ready[g], set last_grant=g and return to IDLE. A new grant can occur in the cycle after the return.
- Latency with zero-wait slave:
  - Write: accept at T0, aw/w valid at T1, bvalid at T2, resp_valid at T3.
  - Read: accept at T0, arvalid at T1, rvalid at T2, resp_valid at T3.
- Boundary conditions:
  - Back-to-back requests from the same requester while another requester is waiting alternate between the two.
  - A single active requester is granted on every IDLE cycle.
  - A req_valid arriving during a transaction waits; it is neither dropped nor reordered.
  - A resp_ready on a non-granted requester is ignored.
  - A slave response with an unexpected extra bvalid or rvalid outside BWAIT/RWAIT is ignored; bready and rready are 0 there.
  - Reset asserted mid-transaction aborts it immediately. No response is returned, and the slave is in the same reset domain.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro: a counter clears on entry to WR or RD and increments every cycle in WR/BWAIT/RD/RWAIT. On reaching TIMEOUT_CYCLES-1:
  - all AXI valids and readies drop;
  - the state goes to RESP with resp_err=1 and resp_rdata=32'hDEAD_0BAD;
  - a sticky internal timeout flag is set, observable in simulation.
  - This deliberately violates AXI valid-hold; it is a recovery path only.
- Without the macro: no counter exists and the arbiter waits indefinitely.

Test Plan:
- Single write: req0 write addr 0x1004, data 0x41, wstrb 0x1; slave zero-wait -> awaddr=0x1004, wdata=0x41 at T1, resp_valid[0] at T3, resp_err=0.
- Single read: req1 read addr 0x1008; slave returns rdata 0x60, rresp 0 -> resp_valid[1] with resp_rdata=0x60, resp_err=0.
- Contention: req0 and req1 both valid at reset release -> req0 is granted first and req1 second; with both held continuously, grants alternate 0,1,0,1 over 4 transactions.
- Skewed handshake: wready 3 cycles before awready -> wvalid drops after wready, awvalid holds until awready, single bready cycle; bresp=2'b10 -> resp_err=1.
- Reset mid-read: assert sys_rst_n=0 in RWAIT -> arvalid, rready and resp_valid are 0 asynchronously; after release, busy=0 and the next request is served normally.
- Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): slave never raises arready -> resp_valid after 16 cycles in RD, resp_err=1, resp_rdata=32'hDEAD_0BAD.
